// File: rtl/prog_loader_if.sv
// Serial-in / BRAM-write bus of the program loader, plus the CPU status lines.
`timescale 1ns/1ps
interface prog_loader_if;
  logic       rx;
  logic [7:0] ram_addr;
  logic [7:0] ram_data;
  logic       ram_we;
  logic       cpu_hold;
  logic       load_done;
  logic       load_err;
  logic [7:0] byte_cnt;

  modport master (
    input  rx,
    output ram_addr, ram_data, ram_we, cpu_hold, load_done, load_err, byte_cnt
  );

  modport slave (
    output rx,
    input  ram_addr, ram_data, ram_we, cpu_hold, load_done, load_err, byte_cnt
  );
endinterface

// File: rtl/prog_loader.sv
// UART-framed bootstrap writer for the program BRAM; holds the CPU until a verified load.
// Optional inter-byte timeout enabled by defining LOADER_TIMEOUT_EN.
`timescale 1ns/1ps
module prog_loader #(
  parameter int unsigned CLK_DIV     = 434,
  parameter logic [7:0]  BASE_ADDR   = 8'h00,
  parameter int unsigned TIMEOUT_CYC = 2_000_000
) (
  input  logic          clk,
  input  logic          rst,
  prog_loader_if.master bus
);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {ST_IDLE, ST_LEN, ST_DATA, ST_SUM, ST_DONE} frame_state_t;

  localparam logic [15:0] HALF_M1   = 16'(CLK_DIV / 2 - 1);
  localparam logic [15:0] FULL_M1   = 16'(CLK_DIV - 1);
  localparam logic [7:0]  SYNC_BYTE = 8'hA5;

  logic         r_rx_meta, r_rx_sync, r_rx_prev;
  rx_state_t    r_rx_st;
  logic [15:0]  r_baud;
  logic [2:0]   r_bit;
  logic [7:0]   r_shift;
  logic         r_rx_valid, r_rx_ferr;
  logic [7:0]   r_rx_byte;

  frame_state_t r_st;
  logic [7:0]   r_ram_addr, r_ram_data, r_byte_cnt, r_sum;
  logic         r_ram_we, r_cpu_hold, r_load_done, r_load_err;
  logic [8:0]   r_remain;
  logic         w_in_frame, w_timeout;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_meta <= bus.rx;
      r_rx_sync <= r_rx_meta;
      r_rx_prev <= r_rx_sync;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_st    <= RX_IDLE;
      r_baud     <= '0;
      r_bit      <= '0;
      r_shift    <= '0;
      r_rx_valid <= 1'b0;
      r_rx_ferr  <= 1'b0;
      r_rx_byte  <= '0;
    end else begin
      r_rx_valid <= 1'b0;
      r_rx_ferr  <= 1'b0;
      case (r_rx_st)
        RX_IDLE: begin
          r_baud <= '0;
          r_bit  <= '0;
          if (r_rx_prev && !r_rx_sync) r_rx_st <= RX_START;
        end
        RX_START: begin
          if (r_baud == HALF_M1) begin
            r_baud  <= '0;
            r_rx_st <= r_rx_sync ? RX_IDLE : RX_DATA;
          end else begin
            r_baud <= r_baud + 16'd1;
          end
        end
        RX_DATA: begin
          if (r_baud == FULL_M1) begin
            r_baud  <= '0;
            r_shift <= {r_rx_sync, r_shift[7:1]};
            r_bit   <= r_bit + 3'd1;
            if (r_bit == 3'd7) r_rx_st <= RX_STOP;
          end else begin
            r_baud <= r_baud + 16'd1;
          end
        end
        RX_STOP: begin
          if (r_baud == FULL_M1) begin
            r_baud  <= '0;
            r_rx_st <= RX_IDLE;
            if (r_rx_sync) begin
              r_rx_valid <= 1'b1;
              r_rx_byte  <= r_shift;
            end else begin
              r_rx_ferr <= 1'b1;
            end
          end else begin
            r_baud <= r_baud + 16'd1;
          end
        end
        default: r_rx_st <= RX_IDLE;
      endcase
    end
  end

  assign w_in_frame = (r_st == ST_LEN) || (r_st == ST_DATA) || (r_st == ST_SUM);

`ifdef LOADER_TIMEOUT_EN
  logic [31:0] r_to_cnt;

  always_ff @(posedge clk) begin
    if (rst || r_rx_valid || !w_in_frame) r_to_cnt <= '0;
    else                                  r_to_cnt <= r_to_cnt + 32'd1;
  end

  assign w_timeout = w_in_frame && !r_rx_valid && (r_to_cnt >= 32'(TIMEOUT_CYC - 1));
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT_CYC != 0);
  assign w_timeout        = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_st        <= ST_IDLE;
      r_ram_addr  <= BASE_ADDR;
      r_ram_data  <= '0;
      r_ram_we    <= 1'b0;
      r_cpu_hold  <= 1'b1;
      r_load_done <= 1'b0;
      r_load_err  <= 1'b0;
      r_byte_cnt  <= '0;
      r_sum       <= '0;
      r_remain    <= '0;
    end else begin
      r_ram_we <= 1'b0;
      if (r_ram_we) r_ram_addr <= r_ram_addr + 8'd1;
      if (w_timeout) begin
        r_load_err <= 1'b1;
        r_st       <= ST_IDLE;
      end else if (r_rx_ferr) begin
        // Framing errors only abort a frame in progress; an idle or loaded state is left alone.
        if (w_in_frame) r_st <= ST_IDLE;
      end else if (r_rx_valid) begin
        case (r_st)
          ST_IDLE, ST_DONE: begin
            if (r_rx_byte == SYNC_BYTE) begin
              r_load_done <= 1'b0;
              r_load_err  <= 1'b0;
              r_cpu_hold  <= 1'b1;
              r_byte_cnt  <= '0;
              r_ram_addr  <= BASE_ADDR;
              r_sum       <= '0;
              r_st        <= ST_LEN;
            end
          end
          ST_LEN: begin
            r_remain <= (r_rx_byte == 8'd0) ? 9'd256 : {1'b0, r_rx_byte};
            r_st     <= ST_DATA;
          end
          ST_DATA: begin
            r_ram_data <= r_rx_byte;
            r_ram_we   <= 1'b1;
            r_sum      <= r_sum + r_rx_byte;
            r_byte_cnt <= r_byte_cnt + 8'd1;
            r_remain   <= r_remain - 9'd1;
            if (r_remain == 9'd1) r_st <= ST_SUM;
          end
          ST_SUM: begin
            if (r_rx_byte == r_sum) begin
              r_load_done <= 1'b1;
              r_cpu_hold  <= 1'b0;
              r_st        <= ST_DONE;
            end else begin
              r_load_err <= 1'b1;
              r_st       <= ST_IDLE;
            end
          end
          default: r_st <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.ram_addr  = r_ram_addr;
  assign bus.ram_data  = r_ram_data;
  assign bus.ram_we    = r_ram_we;
  assign bus.cpu_hold  = r_cpu_hold;
  assign bus.load_done = r_load_done;
  assign bus.load_err  = r_load_err;
  assign bus.byte_cnt  = r_byte_cnt;

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Bootstrap writer for the 8-bit program BRAM. It is the write side of the instruction-fetch path; the CPU core fetches from the same BRAM through a read-only port.
- It receives a framed byte stream on a UART 8N1 line and writes the payload into consecutive program addresses.
- It holds the CPU in its halted state until a load completes with a good checksum.

Parameters:
- CLK_DIV, 434, clk cycles per UART bit (range 16..65535).
- BASE_ADDR, 8'h00, first program address written.
- TIMEOUT_CYC, 2_000_000, maximum idle gap between bytes inside a frame. Used only when LOADER_TIMEOUT_EN is defined.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- rx  in  1  UART serial input, idles high, asynchronous to clk
- ram_addr  out  8  program BRAM write address
- ram_data  out  8  program BRAM write data
- ram_we  out  1  write strobe, one clk pulse per byte
- cpu_hold  out  1  high keeps the CPU halted (PC and registers frozen)
- load_done  out  1  high after a successful load, until the next frame starts or rst
- load_err  out  1  sticky checksum or timeout error, cleared by the next valid sync byte or rst
- byte_cnt  out  8  payload bytes written in the current or last frame

Behaviour:
- Reset values: ram_addr=BASE_ADDR, ram_data=0, ram_we=0, cpu_hold=1, load_done=0, load_err=0, byte_cnt=0. All state returns to IDLE.
- rx passes through a 2-flop synchronizer before use.
- Bit receiver:
  - A falling edge on the synchronized rx starts a frame.
  - The start bit is re-checked at CLK_DIV/2. If it is high, the receiver ignores it as a glitch and returns to line-idle.
  - Data bits are sampled at mid-bit every CLK_DIV cycles, LSB first.
  - Stop bit must be high. A low stop bit is a framing error: the byte is discarded and the frame FSM goes to IDLE. load_err is not set.
  - rx_valid pulses for 1 cycle with the byte.
- Frame FSM states: IDLE, LEN, DATA, SUM, DONE.
  - IDLE: waits for byte 0xA5. Any other byte is ignored. On 0xA5: load_done=0, load_err=0, cpu_hold=1, byte_cnt=0, ram_addr=BASE_ADDR, checksum=0, go to LEN.
  - LEN: latch N. N=0 means 256 bytes. Go to DATA.
  - DATA: on each rx_valid, drive ram_data=byte with ram_we=1 for exactly one cycle at the current ram_addr, all registered on the same edge.
    - The cycle after the write, ram_addr increments modulo 256 (wraps FF->00).
    - checksum += byte (8-bit, carry dropped); byte_cnt += 1 (wraps to 0 after the 256th byte).
    - After N bytes, go to SUM.
  - SUM: if received byte == checksum, go to DONE, else set load_err=1 and go to IDLE.
  - DONE: load_done=1, cpu_hold=0. Stay until the next 0xA5, which re-enters LEN with the effects listed under IDLE.
- cpu_hold is high in every state except DONE. The CPU runs only after a verified load.
- Latency: ram_we asserts 1 clk after rx_valid. cpu_hold falls 1 clk after the checksum byte's rx_valid.
- rst mid-frame aborts immediately: no further ram_we, outputs return to reset values. Bytes already written stay in BRAM.
- A 0xA5 byte inside DATA is payload, not a resync.

Optional Feature:
- Macro: LOADER_TIMEOUT_EN.
- Defined:
  - A counter clears on every rx_valid and counts while in LEN, DATA or SUM.
  - When it reaches TIMEOUT_CYC: set load_err=1, go to IDLE, cpu_hold stays 1.
- Undefined: no counter exists and a stalled frame waits forever. TIMEOUT_CYC is unused.

Test Plan:
- Good load: rst, then send A5 03 11 22 33 66 -> writes 11@00, 22@01, 33@02, one ram_we each; byte_cnt=3; load_done=1; cpu_hold=0; load_err=0.
- Bad checksum: send A5 02 01 02 00 -> two writes; load_err=1; cpu_hold=1; load_done=0. Then a good frame clears load_err.
- Wrap and N=0: BASE_ADDR=8'hF0, send A5 00 followed by 256 bytes of 01 and checksum 00 -> last write at address EF; byte_cnt wraps to 0; load_done=1.
- Garbage and glitch: a 2-cycle low pulse on rx, then bytes 00 FF 5A before A5 01 7E 7E -> the pulse and leading bytes are ignored; one write of 7E; done.
- Reset mid-frame: assert rst after the 2nd of 4 payload bytes -> ram_we stays 0 from then on; outputs at reset values; a subsequent full frame loads correctly.
- LOADER_TIMEOUT_EN with TIMEOUT_CYC=1000: stop after the LEN byte for 1001 clk -> load_err=1, FSM in IDLE, cpu_hold=1.
